icache: RTL
===========

# icache

Direct-mapped, read-only instruction cache that answers `ifetch` lookups and fills misses from the tagged memory bus. It sits between the fetch stage (which drives `proc2Icache_addr` and consumes `Icache2proc_data`/`Icache2proc_data_valid`) and the memory model. It keeps one miss outstanding at a time and matches the returning fill by transaction tag.

## Interface

Parameters:
- `NUM_LINES`, 32: number of 8-byte lines. Must be a power of two. `IDX_BITS = $clog2(NUM_LINES)`.

Ports:
- `clock`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `proc2Icache_addr`  in  `XLEN` (32)  fetch byte address from ifetch.
- `Icache2proc_data`  out  64  8-byte line that holds the requested address.
- `Icache2proc_data_valid`  out  1  `Icache2proc_data` corresponds to the current `proc2Icache_addr`.
- `proc2Imem_command`  out  2  `BUS_NONE` or `BUS_LOAD`; this block never issues `BUS_STORE`.
- `proc2Imem_addr`  out  32  line-aligned fill address.
- `Imem2proc_response`  in  4  transaction tag accepted this cycle; 0 means the request was refused.
- `Imem2proc_data`  in  64  fill data.
- `Imem2proc_tag`  in  4  tag of the data returned this cycle; 0 means no data.

## Operation

Address split:
- `offset = addr[2:0]` (ignored).
- `index = addr[3+IDX_BITS-1:3]`.
- `tag = addr[31:3+IDX_BITS]`.

Storage, per line: `valid` bit, tag, 64-bit data. Only the valid bits need reset.

Hit path (combinational):
- `hit = valid[index] && tags[index] == tag`.
- `Icache2proc_data = data[index]` at all times.
- `Icache2proc_data_valid = hit`.

FSM, two states:
- IDLE
  - On a miss, drive `proc2Imem_command = BUS_LOAD` and `proc2Imem_addr = {addr[31:3], 3'b0}`, both combinational in the same cycle.
  - If `Imem2proc_response != 0`, latch `pend_tag = response`, `pend_index`, and `pend_linetag` from the current address, then go to WAIT.
  - If the response is 0, stay in IDLE. The request is re-driven next cycle.
  - On a hit, drive `BUS_NONE`.
- WAIT
  - Drive `BUS_NONE` and hold address 0. No new request is issued.
  - When `Imem2proc_tag == pend_tag` and `Imem2proc_tag != 0`: write `data[pend_index] = Imem2proc_data`, `tags[pend_index] = pend_linetag`, `valid[pend_index] = 1`, clear `pend_tag`, and go to IDLE.
  - Any other nonzero returning tag is ignored.

Boundary rules:
- The fetch address may change during WAIT. The fill still lands in the line latched at request time. The new address is evaluated normally in IDLE afterwards; it may hit, or it may start a new miss.
- A fill to a line that currently holds a different tag overwrites that line (conflict eviction). No replacement policy is needed.
- Reset at any time, including mid-WAIT:
  - All valid bits cleared.
  - State goes to IDLE and `pend_tag` to 0.
  - A fill arriving after reset carries a stale tag and must not be written.
- `X` or unknown address bits are the producer's responsibility. No sanitising is done.

## Timing

Reset values:
- `Icache2proc_data_valid = 0` (all lines invalid).
- `proc2Imem_command = BUS_NONE`, unless a miss is being presented in the first IDLE cycle after reset, in which case `BUS_LOAD` is driven combinationally.
- `proc2Imem_addr = 0` whenever the command is `BUS_NONE`.

Latency:
- Hit: 0 cycles; valid in the same cycle the address is presented.
- Miss:
  - Request appears in the cycle the address is presented.
  - The fill is written at the posedge of the cycle where the matching `Imem2proc_tag` appears.
  - `Icache2proc_data_valid` rises the following cycle, provided the address is unchanged.
  - Total = memory latency + 1 cycle.
- Refused request: costs one retry cycle per refusal.

Handshake and throughput:
- Response and tag are sampled only at posedge.
- At most one outstanding transaction.
- Throughput on misses: one line per memory round trip.

## Test plan

- Cold miss:
  - Stimulus: reset, then hold addr `0x0000_1004`; memory accepts with response 3; tag 3 returns after N cycles with data `0x1111_1110_2222_2220`.
  - Required: the cycle after the fill, valid=1 and data equals the returned word.
  - Required: exactly one `BUS_LOAD` is issued, to address `0x0000_1000`.
- Hit after fill: addr `0x0000_1000` → valid=1 in the same cycle, command `BUS_NONE`.
- Refusal retry:
  - Stimulus: response=0 for 2 cycles, then 5.
  - Required: `BUS_LOAD` is held for 3 cycles, then `BUS_NONE` in WAIT; the fill with tag 5 completes.
- Conflict eviction, with `NUM_LINES=32`:
  - Stimulus: fill `0x0000_1000`, then fetch `0x0000_1100` (same index, different tag).
  - Required: miss, then refill.
  - Required: refetching `0x0000_1000` misses again.
- Address change mid-miss:
  - Stimulus: miss on `0x2000`, switch to `0x3000` during WAIT.
  - Required: the fill goes to the line for `0x2000`, no second request is issued until WAIT ends, and `0x3000` then misses normally.
- Reset mid-WAIT:
  - Stimulus: pending tag 7, assert reset for one cycle, then return tag 7.
  - Required: no line becomes valid, and valid stays 0 for the original address.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one outstanding tagged fill.
// Hits are combinational; misses issue a single BUS_LOAD and wait for the matching tag.
module icache #(
  parameter int unsigned NUM_LINES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] proc2Icache_addr,
  output logic [63:0] Icache2proc_data,
  output logic        Icache2proc_data_valid,
  output logic [1:0]  proc2Imem_command,
  output logic [31:0] proc2Imem_addr,
  input  logic [3:0]  Imem2proc_response,
  input  logic [63:0] Imem2proc_data,
  input  logic [3:0]  Imem2proc_tag
);

  localparam int unsigned IDX_BITS = $clog2(NUM_LINES);
  localparam int unsigned TAG_BITS = 32 - 3 - IDX_BITS;

  localparam logic [1:0] BUS_NONE = 2'h0;
  localparam logic [1:0] BUS_LOAD = 2'h1;

  typedef enum logic {StIdle, StWait} state_e;

  state_e                state_q, state_d;
  logic [3:0]            pend_tag_q, pend_tag_d;
  logic [IDX_BITS-1:0]   pend_index_q, pend_index_d;
  logic [TAG_BITS-1:0]   pend_linetag_q, pend_linetag_d;

  logic [63:0]           data_q [NUM_LINES];
  logic [TAG_BITS-1:0]   tags_q [NUM_LINES];
  logic [NUM_LINES-1:0]  valid_q;

  logic [IDX_BITS-1:0]   index;
  logic [TAG_BITS-1:0]   line_tag;
  logic                  hit;
  logic                  fill_en;
  logic                  unused_offset;

  assign index         = proc2Icache_addr[3+IDX_BITS-1:3];
  assign line_tag      = proc2Icache_addr[31:3+IDX_BITS];
  assign unused_offset = ^proc2Icache_addr[2:0];

  assign hit = valid_q[index] && (tags_q[index] == line_tag);

  assign Icache2proc_data       = data_q[index];
  assign Icache2proc_data_valid = hit;

  // Tag 0 means "no data" on the bus, so it can never complete a fill.
  assign fill_en = (state_q == StWait) && (Imem2proc_tag != 4'h0) &&
                   (Imem2proc_tag == pend_tag_q);

  always_comb begin
    state_d           = state_q;
    pend_tag_d        = pend_tag_q;
    pend_index_d      = pend_index_q;
    pend_linetag_d    = pend_linetag_q;
    proc2Imem_command = BUS_NONE;
    proc2Imem_addr    = 32'h0;
    unique case (state_q)
      StIdle: begin
        if (!hit) begin
          proc2Imem_command = BUS_LOAD;
          proc2Imem_addr    = {proc2Icache_addr[31:3], 3'b000};
          if (Imem2proc_response != 4'h0) begin
            pend_tag_d     = Imem2proc_response;
            pend_index_d   = index;
            pend_linetag_d = line_tag;
            state_d        = StWait;
          end
        end
      end
      StWait: begin
        if (fill_en) begin
          pend_tag_d = 4'h0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      pend_tag_q     <= 4'h0;
      pend_index_q   <= '0;
      pend_linetag_q <= '0;
      valid_q        <= '0;
    end else begin
      state_q        <= state_d;
      pend_tag_q     <= pend_tag_d;
      pend_index_q   <= pend_index_d;
      pend_linetag_q <= pend_linetag_d;
      if (fill_en) valid_q[pend_index_q] <= 1'b1;
    end
  end

  // Data and tag arrays need no reset; the valid bits qualify them.
  always_ff @(posedge clock) begin
    if (fill_en && !reset) begin
      data_q[pend_index_q] <= Imem2proc_data;
      tags_q[pend_index_q] <= pend_linetag_q;
    end
  end

endmodule
